// File: rtl/key_pkg.sv
// Shared widths and the bitmap-index-to-code helper for the keypad event path.
package key_pkg;

  localparam int NUM_KEYS   = 16;
  localparam int KEY_CODE_W = 4;
  localparam int KEY_MAP_W  = 17;

  // Scanner bitmap index n (1..16) maps to key code n-1.
  function automatic logic [KEY_CODE_W-1:0] key_code_of(input int unsigned n);
    return KEY_CODE_W'(n - 1);
  endfunction

endpackage

// File: rtl/key_event_encoder_debounce.sv
// Per-key debouncer: down-to-zero restart counter plus the debounced level flop.
module key_debounce_bit #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             flip;

  assign flip = (raw != held) && (cnt == CNT_LAST);
  // Combinational so the press is recorded on the same edge that held flips.
  assign rise = flip && raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      held <= 1'b0;
    end else if (raw == held) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      held <= raw;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Debounces the 16 scanner keys and queues press events as 4-bit codes on a
// valid/ready output, lowest code first, with a sticky lost-event flag.
module key_event_encoder
  import key_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_MAP_W-1:0]  key,
  output logic [NUM_KEYS-1:0]   held,
  output logic                  code_valid,
  input  logic                  code_ready,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  overflow
);

  logic [NUM_KEYS-1:0]   rise;
  logic [NUM_KEYS-1:0]   pending;
  logic [NUM_KEYS-1:0]   pending_next;
  logic [NUM_KEYS-1:0]   sel_onehot;
  logic [NUM_KEYS-1:0]   consume;
  logic [KEY_CODE_W-1:0] sel_code;
  logic                  out_free;
  logic                  lost_event;
  logic                  unused_key0;

  assign unused_key0 = key[0];

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_db
    key_debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (key[g+1]),
      .held (held[g]),
      .rise (rise[g])
    );
  end

  assign out_free   = !code_valid || code_ready;
  // Isolate the lowest set pending bit.
  assign sel_onehot = pending & (~pending + NUM_KEYS'(1));
  assign consume    = out_free ? sel_onehot : '0;

  always_comb begin
    sel_code = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (sel_onehot[i]) sel_code = key_code_of(i + 1);
    end
  end

  // A new press re-sets its bit even if it is being drained this edge.
  always_comb begin
    pending_next = (pending & ~consume) | rise;
    lost_event   = |(rise & pending & ~consume);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      code_valid <= 1'b0;
      key_code   <= '0;
      overflow   <= 1'b0;
    end else begin
      pending <= pending_next;
      if (lost_event) overflow <= 1'b1;
      if (out_free) begin
        if (|pending) begin
          code_valid <= 1'b1;
          key_code   <= sel_code;
        end else begin
          code_valid <= 1'b0;
        end
      end
    end
  end

endmodule
